// File: rtl/count_sweep_ctrl.sv
// Bounded up/down sweep counter: runs n_sweeps lo->hi->lo passes, then pulses done.
// Optional stall input enabled by defining SWEEP_PAUSE_EN.
module count_sweep_ctrl #(
  parameter int WIDTH    = 3,
  parameter int SWEEPS_W = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [WIDTH-1:0]    lo,
  input  logic [WIDTH-1:0]    hi,
  input  logic [SWEEPS_W-1:0] n_sweeps,
`ifdef SWEEP_PAUSE_EN
  input  logic                pause,
`endif
  output logic [WIDTH-1:0]    count,
  output logic                dir_up,
  output logic                busy,
  output logic                done,
  output logic [SWEEPS_W-1:0] sweep_cnt
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [SWEEPS_W-1:0] sweep_q, sweep_d, n_q, n_d;
  logic                stall;

`ifdef SWEEP_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      count_q <= '0;
      sweep_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sweep_q <= sweep_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sweep_d = sweep_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    case (state_q)
      IDLE: if (start) begin
        lo_d    = lo;
        hi_d    = hi;
        n_d     = n_sweeps;
        count_d = lo;
        sweep_d = '0;
        // Empty range or zero sweeps finishes immediately without going busy.
        state_d = (lo < hi && n_sweeps != '0) ? UP : DONE;
      end
      UP: if (!stall) begin
        if (count_q == hi_q) begin
          state_d = DOWN;
          count_d = count_q - WIDTH'(1);
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      DOWN: if (!stall) begin
        if (count_q == lo_q) begin
          sweep_d = sweep_q + SWEEPS_W'(1);
          if (sweep_d == n_q) begin
            state_d = DONE;
          end else begin
            state_d = UP;
            count_d = lo_q + WIDTH'(1);
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign count     = count_q;
  assign sweep_cnt = sweep_q;
  assign dir_up    = (state_q != DOWN);
  assign busy      = (state_q == UP) || (state_q == DOWN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Directed bench for count_sweep_ctrl; pause scenario built only with SWEEP_PAUSE_EN.
module tb_count_sweep_ctrl;
  logic       clk = 1'b0;
  logic       clear, start;
  logic [2:0] lo, hi;
  logic [3:0] n_sweeps;
`ifdef SWEEP_PAUSE_EN
  logic       pause;
`endif
  logic [2:0] count;
  logic       dir_up, busy, done;
  logic [3:0] sweep_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  count_sweep_ctrl #(.WIDTH(3), .SWEEPS_W(4)) dut (
    .clk(clk), .clear(clear), .start(start), .lo(lo), .hi(hi), .n_sweeps(n_sweeps),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .count(count), .dir_up(dir_up), .busy(busy), .done(done), .sweep_cnt(sweep_cnt)
  );

  // Advance one rising edge; outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; lo = 3'd0; hi = 3'd0; n_sweeps = 4'd0;
`ifdef SWEEP_PAUSE_EN
    pause = 1'b0;
`endif
    @(negedge clk);
    step(); step();
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || dir_up !== 1'b1 || sweep_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset: count=%0d busy=%b done=%b dir_up=%b sweep_cnt=%0d, want 0 0 0 1 0",
               count, busy, done, dir_up, sweep_cnt);
    end
    clear = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int exp_cnt [8] = '{2, 3, 4, 5, 4, 3, 2, 2};
    start = 1'b1; lo = 3'd2; hi = 3'd5; n_sweeps = 4'd1;
    step();
    start = 1'b0; lo = 3'd7; hi = 3'd1; n_sweeps = 4'd9;  // must not affect running job
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (count !== 3'(exp_cnt[c-1]) || busy !== (c <= 7) || done !== (c == 8) ||
          dir_up !== !(c >= 5 && c <= 7)) begin
        n_fail++;
        $display("FAIL basic c%0d: count=%0d busy=%b done=%b dir_up=%b, want %0d %b %b %b",
                 c, count, busy, done, dir_up, exp_cnt[c-1], c <= 7, c == 8, !(c >= 5 && c <= 7));
      end
      step();
    end
    n_checks++;
    if (sweep_cnt !== 4'd1 || done !== 1'b0 || busy !== 1'b0 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL basic_idle: sweep_cnt=%0d done=%b busy=%b count=%0d, want 1 0 0 2",
               sweep_cnt, done, busy, count);
    end
  endtask

  task automatic test_full_range();
    int pos, exp;
    start = 1'b1; lo = 3'd0; hi = 3'd7; n_sweeps = 4'd2;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      pos = (c - 1) % 14;
      exp = (c == 30) ? 0 : ((pos <= 7) ? pos : 14 - pos);
      n_checks++;
      if (count !== 3'(exp) || busy !== (c <= 29) || done !== (c == 30)) begin
        n_fail++;
        $display("FAIL full_range c%0d: count=%0d busy=%b done=%b, want %0d %b %b",
                 c, count, busy, done, exp, c <= 29, c == 30);
      end
      step();
    end
    n_checks++;
    if (sweep_cnt !== 4'd2 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_range_end: sweep_cnt=%0d done=%b, want 2 0", sweep_cnt, done);
    end
  endtask

  task automatic test_degenerate();
    logic [2:0] l_v [2] = '{3'd4, 3'd1};
    logic [2:0] h_v [2] = '{3'd4, 3'd6};
    logic [3:0] n_v [2] = '{4'd3, 4'd0};
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; lo = l_v[k]; hi = h_v[k]; n_sweeps = n_v[k];
      step();
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || count !== l_v[k]) begin
        n_fail++;
        $display("FAIL degenerate%0d c1: done=%b busy=%b count=%0d, want 1 0 %0d",
                 k, done, busy, count, l_v[k]);
      end
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== l_v[k]) begin
        n_fail++;
        $display("FAIL degenerate%0d c2: done=%b busy=%b count=%0d, want 0 0 %0d",
                 k, done, busy, count, l_v[k]);
      end
    end
  endtask

  task automatic test_clear_mid();
    int seen_done;
    start = 1'b1; lo = 3'd2; hi = 3'd5; n_sweeps = 4'd1;
    step();
    start = 1'b0;
    step(); step(); step();  // cycle 4: count=5
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || sweep_cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_mid: count=%0d busy=%b sweep_cnt=%0d done=%b, want 0 0 0 0",
               count, busy, sweep_cnt, done);
    end
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL clear_mid_quiet: done/busy cycles=%0d, want 0", seen_done);
    end
    // Abort during the second sweep, once sweep_cnt has advanced.
    start = 1'b1; n_sweeps = 4'd2;
    step();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    n_checks++;
    if (sweep_cnt !== 4'd1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL clear_mid2_pre: sweep_cnt=%0d count=%0d, want 1 4", sweep_cnt, count);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (sweep_cnt !== 4'd0 || count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_mid2: sweep_cnt=%0d count=%0d busy=%b, want 0 0 0", sweep_cnt, count, busy);
    end
  endtask

  task automatic test_clear_start();
    clear = 1'b1; start = 1'b1; lo = 3'd1; hi = 3'd6; n_sweeps = 4'd1;
    step();
    clear = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_start: busy=%b count=%0d done=%b, want 0 0 0", busy, count, done);
    end
  endtask

  task automatic test_back_to_back();
    int exp_cnt [8] = '{2, 3, 4, 5, 4, 3, 2, 2};
    start = 1'b1; lo = 3'd2; hi = 3'd5; n_sweeps = 4'd1;
    step();
    lo = 3'd0; hi = 3'd3;  // start stays high for the whole job
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (count !== 3'(exp_cnt[c-1]) || done !== (c == 8)) begin
        n_fail++;
        $display("FAIL back_to_back c%0d: count=%0d done=%b, want %0d %b",
                 c, count, done, exp_cnt[c-1], c == 8);
      end
      step();
    end
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL back_to_back idle: busy=%b count=%0d, want 0 2", busy, count);
    end
    step();
    n_checks++;
    if (busy !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL back_to_back restart: busy=%b count=%0d, want 1 0", busy, count);
    end
    start = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

`ifdef SWEEP_PAUSE_EN
  task automatic test_pause();
    start = 1'b1; lo = 3'd2; hi = 3'd5; n_sweeps = 4'd1;
    step();
    start = 1'b0;
    step(); step();  // cycle 3: count=4
    pause = 1'b1;
    for (int c = 4; c <= 6; c++) begin
      step();
      n_checks++;
      if (count !== 3'd4 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pause c%0d: count=%0d busy=%b, want 4 1", c, count, busy);
      end
    end
    pause = 1'b0;
    for (int c = 7; c <= 11; c++) step();
    n_checks++;
    if (done !== 1'b1 || count !== 3'd2 || sweep_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL pause_done: done=%b count=%0d sweep_cnt=%0d, want 1 2 1", done, count, sweep_cnt);
    end
    step();
    // pause in IDLE must not block acceptance
    pause = 1'b1; start = 1'b1; lo = 3'd1;
    step();
    pause = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL pause_idle: busy=%b count=%0d, want 1 1", busy, count);
    end
    clear = 1'b1; pause = 1'b1;
    step();
    clear = 1'b0; pause = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL pause_clear: busy=%b count=%0d, want 0 0", busy, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_degenerate();
    test_clear_mid();
    test_clear_start();
    test_back_to_back();
`ifdef SWEEP_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_sweep_ctrl.md
COUNT_SWEEP_CTRL -- requirements
Module: count_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits.
REQ-002 Parameter SWEEPS_W, default 4: width of the sweep-count operand and status.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin a sweep job; sampled only in IDLE.
REQ-006 lo  input  WIDTH  lower sweep bound; captured on the accepted start.
REQ-007 hi  input  WIDTH  upper sweep bound; captured on the accepted start.
REQ-008 n_sweeps  input  SWEEPS_W  number of full lo->hi->lo sweeps; captured on the accepted start.
REQ-009 pause  input  1  stall request; port exists only with SWEEP_PAUSE_EN.
REQ-010 count  output  WIDTH  current counter value, registered.
REQ-011 dir_up  output  1  1 in IDLE, UP and DONE; 0 in DOWN.
REQ-012 busy  output  1  1 in UP and DOWN only.
REQ-013 done  output  1  single-cycle pulse, high only in DONE.
REQ-014 sweep_cnt  output  SWEEPS_W  completed sweeps of the current or last job.

Function
REQ-015 The FSM SHALL have states IDLE, UP, DOWN and DONE, and all outputs SHALL be registered or decoded from state only.
REQ-016 Timing convention: cycle N is the Nth rising edge after the edge that samples start.
REQ-017 In IDLE with start=1, the block SHALL capture lo, hi and n_sweeps, clear sweep_cnt and set count=lo at cycle 1.
REQ-018 On that same accepted start, the block SHALL enter UP if lo<hi and n_sweeps!=0, and SHALL otherwise enter DONE.
REQ-019 In UP, count SHALL increment by 1 per cycle; on the cycle count equals captured hi, the next state SHALL be DOWN and count SHALL become hi-1.
REQ-020 In DOWN, count SHALL decrement by 1 per cycle until count equals captured lo.
REQ-021 On the cycle DOWN reaches lo, sweep_cnt SHALL increment.
REQ-022 On that same cycle, the next state SHALL be DONE if the incremented sweep_cnt equals n_sweeps, with count holding lo.
REQ-023 On that same cycle, if more sweeps remain, the next state SHALL be UP and count SHALL become lo+1.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-025 count SHALL never leave [lo, hi] during a job, so no modulo wrap-around occurs, including at lo=0 and hi=2^WIDTH-1.
REQ-026 start SHALL be ignored in UP, DOWN and DONE.
REQ-027 lo, hi and n_sweeps SHALL be ignored except on the accepted start.
REQ-028 In IDLE, count, sweep_cnt and the captured operands SHALL hold their last values.
REQ-029 If clear and start are asserted in the same cycle, clear SHALL win.

Reset
REQ-030 clear=1 at a rising edge SHALL force state IDLE, count=0, sweep_cnt=0, dir_up=1, busy=0, done=0 and zero all captured operands, in any state.
REQ-031 A clear mid-job SHALL abort the job with no done pulse.

Configuration
REQ-032 With SWEEP_PAUSE_EN defined, pause=1 in UP or DOWN SHALL hold state, count and sweep_cnt, with busy remaining 1.
REQ-033 With SWEEP_PAUSE_EN defined, pause SHALL be ignored in IDLE and DONE, and clear SHALL override pause.
REQ-034 Without SWEEP_PAUSE_EN, the pause port SHALL be absent and the block SHALL never stall.

Verification
REQ-035 lo=2, hi=5, n=1 -> count 2,3,4,5,4,3,2 at cycles 1-7; busy at cycles 1-7; done only at cycle 8; sweep_cnt=1; dir_up=0 at cycles 5-7.
REQ-036 lo=0, hi=7, n=2 -> count reaches 7 at cycles 8 and 22 and 0 at cycles 1, 15 and 29; done at cycle 30; no wrap; sweep_cnt=2.
REQ-037 lo=4, hi=4, n=3 and separately lo=1, hi=6, n=0 -> DONE at cycle 1; busy never 1; count=lo.
REQ-038 clear at cycle 4 of the REQ-035 job -> next edge count=0, busy=0, sweep_cnt=0; no done pulse.
REQ-039 start=1 with lo=0, hi=3 held high through a running REQ-035 job -> job unaffected; a new job starts only from IDLE.
REQ-040 With SWEEP_PAUSE_EN, pause=1 for 3 cycles at count=4 in UP -> count holds 4 for 3 cycles; done slips by 3 cycles.
